// File: rtl/serial_halfadd_sched.sv
// -----------------------------------------------------------------------------
// serial_halfadd_sched
//
// Performs a WIDTH-bit add, LSB first, by time-sharing a single AND/XOR
// half-adder cell. Each operand bit uses the cell twice:
//   PASS1 : x=a[idx], y=b[idx]    -> s1 = x^y, c1 = x&y
//   PASS2 : x=s1,     y=carry     -> acc[idx] = x^y, carry = c1 | (x&y)
// After the last bit the result is registered into sum/cout, and done
// pulses for one cycle.
//
// Ports
//   clk    : system clock; all state updates on the rising edge
//   rst    : synchronous active-high reset; aborts any add in progress
//   start  : request pulse, sampled only while idle
//   a, b   : WIDTH-bit operands, captured on the accepted start edge
//   cin    : carry-in, captured on the accepted start edge
//   busy   : high while the bit passes are running
//   done   : one-cycle pulse in the cycle sum/cout show a new result
//   sum    : registered result; holds the last completed value
//   cout   : registered carry-out; holds the last completed value
// -----------------------------------------------------------------------------
module serial_halfadd_sched #(
    parameter int WIDTH = 4,
    parameter int IDXW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDXW-1:0]  r_idx;
    logic             r_s1;
    logic             r_c1;
    logic             r_carry;
    logic [WIDTH-1:0] r_acc;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [WIDTH-1:0] w_bit_mask;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_ha_x;
    logic             w_ha_y;
    logic             w_ha_s;
    logic             w_ha_c;
    logic             w_last_bit;

    // Shared half-adder cell: operand mux selects which pass is using it.
    always_comb begin
        w_a_sh     = r_a >> r_idx;
        w_b_sh     = r_b >> r_idx;
        w_bit_mask = WIDTH'(1) << r_idx;
        w_last_bit = (r_idx == IDXW'(WIDTH - 1));
        w_ha_x     = 1'b0;
        w_ha_y     = 1'b0;
        if (r_state == S_PASS1) begin
            w_ha_x = w_a_sh[0];
            w_ha_y = w_b_sh[0];
        end else if (r_state == S_PASS2) begin
            w_ha_x = r_s1;
            w_ha_y = r_carry;
        end else begin
            w_ha_x = 1'b0;
            w_ha_y = 1'b0;
        end
        w_ha_s = w_ha_x ^ w_ha_y;
        w_ha_c = w_ha_x & w_ha_y;
        // Accumulator with the current bit written, so the final bit can be
        // folded into sum on the same edge that enters DONE.
        if (w_ha_s) begin
            w_acc_next = r_acc | w_bit_mask;
        end else begin
            w_acc_next = r_acc & ~w_bit_mask;
        end
    end

    // Sequencer FSM with registered busy/done/sum/cout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_s1    <= 1'b0;
            r_c1    <= 1'b0;
            r_carry <= 1'b0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_PASS1;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_PASS1: begin
                    r_s1    <= w_ha_s;
                    r_c1    <= w_ha_c;
                    r_state <= S_PASS2;
                end
                S_PASS2: begin
                    r_acc   <= w_acc_next;
                    r_carry <= r_c1 | w_ha_c;
                    if (w_last_bit) begin
                        // Results and done become visible together in DONE.
                        r_sum   <= w_acc_next;
                        r_cout  <= r_c1 | w_ha_c;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + IDXW'(1);
                        r_state <= S_PASS1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_halfadd_sched.sv
// -----------------------------------------------------------------------------
// Self-checking bench for serial_halfadd_sched (WIDTH=4).
// A transaction-level model tracks, per accepted add, how many cycles remain
// until the unit is idle again and what {cout,sum} = a+b+cin must be. A
// compare process checks busy/done/sum/cout against it every cycle; directed
// tasks add literal expectations for latency and results.
// -----------------------------------------------------------------------------
module tb_serial_halfadd_sched;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    serial_halfadd_sched #(.WIDTH(W), .IDXW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_rem: cycles until idle again (0 = idle). An accepted add occupies
    // 2*W busy cycles followed by one done cycle.
    int           m_rem = 0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic [W:0]   m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem  = 0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else if (m_rem == 0) begin
            if (start) begin
                m_pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_rem  = 2 * W + 1;
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 1) begin
                m_sum  = m_pend[W-1:0];
                m_cout = m_pend[W];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_outputs",
                  {24'd0, busy, done, cout, 1'b0, sum},
                  {24'd0, (m_rem >= 2), (m_rem == 1), m_cout, 1'b0, m_sum});
        end
    end

    // Issue one add from idle and check latency, busy length and result.
    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                           input logic [W-1:0] esum, input logic ecout);
        int lat;
        int bcnt;
        @(posedge clk); #1;
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
        // done is seen 2*W edges after the accepting edge (cycle start+9 for W=4)
        check("latency", 32'(lat), 32'(2 * W));
        check("busy_len", 32'(bcnt), 32'(2 * W));
        check("sum", 32'(sum), 32'(esum));
        check("cout", 32'(cout), 32'(ecout));
    endtask

    initial begin
        int ndone;
        int dt[$];
        logic [W:0] r;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        check("reset_state", {28'd0, busy, done, cout, 1'b0}, 32'd0);
        check("reset_sum", 32'(sum), 32'd0);

        run_add(4'd3, 4'd5, 1'b0, 4'd8, 1'b0);
        run_add(4'd15, 4'd1, 1'b0, 4'd0, 1'b1);
        run_add(4'd15, 4'd15, 1'b1, 4'd15, 1'b1);

        // start pulse during an add is ignored
        @(posedge clk); #1;
        a = 4'd2; b = 4'd2; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 a = 4'd7; b = 4'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                check("ignored_start_sum", {27'd0, cout, sum}, 32'd4);
            end
        end
        check("ignored_start_ndone", 32'(ndone), 32'd1);

        // reset in the middle of an add
        @(posedge clk); #1;
        a = 4'd9; b = 4'd9; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("abort_state", {27'd0, busy, done, cout, sum}, 32'd0);
        run_add(4'd1, 4'd1, 1'b0, 4'd2, 1'b0);

        // start held high: one add every 2*W+2 cycles
        @(posedge clk); #1;
        a = 4'd6; b = 4'd3; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        for (int t = 1; t <= 30; t++) begin
            @(posedge clk); #1;
            if (done) begin
                dt.push_back(t);
                check("held_sum", {27'd0, cout, sum}, 32'd9);
            end
        end
        start = 1'b0;
        check("held_ndone", 32'(dt.size()), 32'd3);
        if (dt.size() == 3) begin
            check("held_t0", 32'(dt[0]), 32'd8);
            check("held_t1", 32'(dt[1]), 32'd18);
            check("held_t2", 32'(dt[2]), 32'd28);
        end
        repeat (12) @(posedge clk);

        // exhaustive operands and carry-in
        for (int i = 0; i < 256; i++) begin
            for (int c = 0; c < 2; c++) begin
                r = 5'(i / 16) + 5'(i % 16) + 5'(c);
                run_add(W'(i / 16), W'(i % 16), 1'(c), r[W-1:0], r[W]);
            end
        end

        // random traffic with occasional resets; model checks every cycle
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            rst = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_halfadd_sched.md
Name: serial_halfadd_sched

Overview:
- Sequencer that time-shares one AND/XOR half-adder cell to perform a WIDTH-bit add serially, LSB first.
- Each operand bit uses the cell twice. Pass 1 computes a^b and a&b. Pass 2 combines that partial sum with the running carry.
- Sits between a requester issuing start/operand pairs and the single shared half-adder resource.
- Result is registered and presented with a one-cycle done pulse.

Parameters:
- WIDTH, 4, operand and sum width in bits. Legal values are 1 to 32.
- IDXW, 5, width of the internal bit-index counter. Must satisfy 2**IDXW >= WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepted start edge
- b  input  WIDTH  operand B; captured on the accepted start edge
- cin  input  1  carry-in; captured on the accepted start edge
- busy  output  1  high while PASS1/PASS2 are in progress
- done  output  1  one-cycle pulse when sum/cout update
- sum  output  WIDTH  registered result; holds the last completed result
- cout  output  1  registered carry-out; holds the last completed result

Behaviour:
- Reset is one clock, synchronous, active-high, and has priority over everything.
  - On reset: state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal operand regs, bit index, s1, c1 and carry are cleared.
- Reset mid-operation aborts the add. No done is generated and sum/cout go to 0.
- FSM states: IDLE, PASS1, PASS2, DONE.
- IDLE:
  - If start=1: latch a, b, cin (carry<=cin), idx<=0, go to PASS1. Otherwise stay.
  - busy=0, done=0.
- PASS1 (shared cell, pass 1): s1<=a[idx]^b[idx]; c1<=a[idx]&b[idx]; go to PASS2.
- PASS2 (shared cell, pass 2):
  - acc[idx]<=s1^carry; carry<=c1|(s1&carry).
  - If idx==WIDTH-1: go to DONE. Else idx<=idx+1 and go to PASS1.
- DONE:
  - sum<=acc with bit WIDTH-1 included (the final bit is written on the same edge). cout<=final carry.
  - done=1 for exactly this cycle; busy=0. Next state is IDLE.
- busy=1 in PASS1 and PASS2 only.
- start is ignored in PASS1, PASS2 and DONE. There is no queuing, and operands presented then are discarded.
- Latency: start accepted at edge N; busy rises in cycle N+1; done is high in cycle N+2*WIDTH+1. For WIDTH=4, done is 9 cycles after the start edge.
- Throughput: one add per 2*WIDTH+2 cycles. With start held high continuously, the next add is accepted on the first IDLE cycle after DONE.
- sum/cout do not change during busy; they still show the previous result. They change only on the edge entering DONE.
- a, b and cin may change freely after the accepted start edge without affecting the result.
- Arithmetic is modulo 2**WIDTH, with the overflow carry in cout: {cout,sum} = a+b+cin.
- WIDTH=1: PASS1, PASS2, DONE, so done is 3 cycles after start.

Test Plan:
- WIDTH=4, reset then start with a=3, b=5, cin=0 -> done pulses exactly 9 cycles after the start edge; sum=8, cout=0; busy high for 8 cycles.
- a=15, b=1, cin=0 -> sum=0, cout=1. Then a=15, b=15, cin=1 -> sum=15, cout=1. Previous sum is held (0) until the second done.
- Start a=2, b=2; pulse start with a=7, b=7 at cycle 3 -> ignored; result sum=4, cout=0; only one done pulse.
- Assert rst for one cycle at cycle 5 of an add with a=9, b=9 -> no done; sum=0, cout=0, busy=0 the next cycle. A fresh start with a=1, b=1 -> sum=2 after 9 cycles.
- Hold start high continuously with a=6, b=3 -> dones in cycles 9, 19, 29 (period 10); each sum=9, cout=0; start during DONE not accepted.
- Exhaustive 256 a/b pairs x cin, compared against a reference add -> every {cout,sum} matches, and every done is at start+9.
